// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-detector FSM state encoding and helpers.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package adpll_pkg;

    // Encodings are visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_SLIP    = 2'd3
    } lock_state_t;

    // True for the states in which the loop is reported as locked.
    function automatic logic holds_lock(input lock_state_t s);
        return (s == ST_LOCKED) || (s == ST_SLIP);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous clock into clk's domain and emits a one-cycle pulse per rising edge.
// Latency: pulse is high 3 clk cycles after the async rising edge (2 sync flops + registered detect).
// Backpressure: none; every edge seen after the synchronizer has filled yields one pulse.
//
// Ports: clk, rst_n (async active-low), async_in (asynchronous level), pulse (one-cycle strobe).
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic       meta;
    logic       sync;
    logic       sync_prev;
    logic [1:0] fill_cnt;

    // fill_cnt holds off detection until meta, sync and sync_prev all carry real
    // samples of async_in, so an input that is already high when reset releases
    // is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            sync_prev <= 1'b0;
            fill_cnt  <= 2'd0;
            pulse     <= 1'b0;
        end else begin
            meta      <= async_in;
            sync      <= meta;
            sync_prev <= sync;
            if (fill_cnt != 2'd3) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            pulse     <= (fill_cnt == 2'd3) && sync && !sync_prev;
        end
    end

endmodule

// File: rtl/lock_detector.sv
// Phase-lock detector: qualifies phase-error samples taken on ref_clk_i edges and tracks lock.
// Latency: ref edge -> strobe 3 cycles, error captured on strobe, FSM/outputs update 2 cycles later.
// Backpressure: none; samples arriving while disabled or idle are dropped.
//
// Ports: fpga_clk_i/reset_i (async active-low) clock and reset; enable_i detector enable;
//        ref_clk_i asynchronous reference; error_i signed phase error;
//        locked_o, lock_lost_o (1-cycle pulse), state_o, good_cnt_o, timeout_o status.
// Optional feature: define LOCK_DET_TIMEOUT_EN to add the sample watchdog (TIMEOUT_CYCLES);
//        otherwise timeout_o is tied low.
module lock_detector
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH  = 8,
    parameter int LOCK_TOL     = 2,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 8
`ifdef LOCK_DET_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic                          ref_clk_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic                          locked_o,
    output logic                          lock_lost_o,
    output logic [1:0]                    state_o,
    output logic [CNT_WIDTH-1:0]          good_cnt_o,
    output logic                          timeout_o
);

    localparam logic [CNT_WIDTH-1:0] LOCK_N   = CNT_WIDTH'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_N = CNT_WIDTH'(UNLOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Tolerance is compared on a one-bit-wider signed value, so the most
    // negative code compares correctly without needing abs().
    localparam logic signed [ERROR_WIDTH:0] TOL_HI = (ERROR_WIDTH+1)'(LOCK_TOL);
    localparam logic signed [ERROR_WIDTH:0] TOL_LO = -TOL_HI;

    logic                          strobe;
    logic                          sample_vld;
    logic signed [ERROR_WIDTH-1:0] err_q;
    logic signed [ERROR_WIDTH:0]   err_ext;
    logic                          in_tol;
    logic                          wd_fire;

    lock_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] good_q, good_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 lost_d;
    logic                 locked_q;
    logic                 lost_q;

    edge_sync u_edge_sync (
        .clk      (fpga_clk_i),
        .rst_n    (reset_i),
        .async_in (ref_clk_i),
        .pulse    (strobe)
    );

    // A strobe seen while enable_i is low (including the cycle it falls) is
    // never turned into a sample.
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            err_q      <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= strobe && enable_i;
            if (strobe && enable_i) begin
                err_q <= error_i;
            end
        end
    end

    assign err_ext = {err_q[ERROR_WIDTH-1], err_q};
    assign in_tol  = (err_ext >= TOL_LO) && (err_ext <= TOL_HI);

`ifdef LOCK_DET_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_fire = (state_q != ST_IDLE) && !strobe &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) || strobe || wd_fire) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if ((state_q == ST_IDLE) || strobe) begin
                timeout_q <= 1'b0;
            end else if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            // Derived from next state so LOCKED<->SLIP never dips locked_o.
            locked_q <= holds_lock(state_d);
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        lost_d  = 1'b0;

        if (!enable_i) begin
            // Disabling is a deliberate stop, not a loss of lock: no pulse.
            state_d = ST_IDLE;
            good_d  = '0;
            miss_d  = '0;
        end else if (wd_fire) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
            miss_d  = '0;
            lost_d  = holds_lock(state_q);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                    miss_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (sample_vld) begin
                        if (in_tol) begin
                            good_d = good_q + CNT_ONE;
                            if (good_d >= LOCK_N) begin
                                state_d = ST_LOCKED;
                                good_d  = LOCK_N;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sample_vld) begin
                        if (in_tol) begin
                            if (good_q < LOCK_N) begin
                                good_d = good_q + CNT_ONE;
                            end
                        end else if (UNLOCK_N <= CNT_ONE) begin
                            state_d = ST_ACQUIRE;
                            good_d  = '0;
                            miss_d  = '0;
                            lost_d  = 1'b1;
                        end else begin
                            // good_cnt is held through SLIP: the lock is still claimed.
                            state_d = ST_SLIP;
                            miss_d  = CNT_ONE;
                        end
                    end
                end
                ST_SLIP: begin
                    if (sample_vld) begin
                        if (in_tol) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + CNT_ONE;
                            if (miss_d >= UNLOCK_N) begin
                                state_d = ST_ACQUIRE;
                                good_d  = '0;
                                miss_d  = '0;
                                lost_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign state_o     = state_q;
    assign good_cnt_o  = good_q;
    assign locked_o    = locked_q;
    assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_lock_detector.sv
// Directed bench for lock_detector: acquisition, slip recovery, loss of lock,
// enable/reset behaviour and (with LOCK_DET_TIMEOUT_EN) the sample watchdog.
module tb_lock_detector;

    logic              fpga_clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              ref_clk;
    logic signed [7:0] error;
    logic              locked;
    logic              lock_lost;
    logic [1:0]        state;
    logic [7:0]        good_cnt;
    logic              timeout;

    int n_checks    = 0;
    int n_errors    = 0;
    int lost_pulses = 0;
    int lost_base;

    always #5 fpga_clk = ~fpga_clk;

    lock_detector dut (
        .fpga_clk_i  (fpga_clk),
        .reset_i     (reset_n),
        .enable_i    (enable),
        .ref_clk_i   (ref_clk),
        .error_i     (error),
        .locked_o    (locked),
        .lock_lost_o (lock_lost),
        .state_o     (state),
        .good_cnt_o  (good_cnt),
        .timeout_o   (timeout)
    );

    // Counts cycles with lock_lost high, so a stretched pulse also shows up.
    always @(negedge fpga_clk) begin
        if (lock_lost === 1'b1) lost_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 1 MHz reference period (100 fpga_clk cycles) carrying one error sample.
    task automatic send(input int err);
        error   = 8'(err);
        ref_clk = 1'b1;
        repeat (50) @(negedge fpga_clk);
        ref_clk = 1'b0;
        repeat (50) @(negedge fpga_clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        ref_clk = 1'b1;
        error   = 8'sd0;
        repeat (3) @(negedge fpga_clk);
        check("rst_state",   state,     0);
        check("rst_locked",  locked,    0);
        check("rst_lost",    lock_lost, 0);
        check("rst_good",    good_cnt,  0);
        check("rst_timeout", timeout,   0);

        // Reference already high at reset release: no sample must appear.
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (10) @(negedge fpga_clk);
        check("acq_after_en",     state,    1);
        check("no_strobe_ref_hi", good_cnt, 0);
        ref_clk = 1'b0;
        repeat (10) @(negedge fpga_clk);

        // Acquisition with error=+1; exact cycle of locked rise on the 16th.
        for (int i = 0; i < 15; i++) send(1);
        check("acq15_good",   good_cnt, 15);
        check("acq15_locked", locked,   0);
        error   = 8'sd1;
        ref_clk = 1'b1;
        repeat (4) @(negedge fpga_clk);
        check("acq16_eval_locked", locked, 0);
        check("acq16_eval_state",  state,  1);
        @(negedge fpga_clk);
        check("acq16_locked", locked,   1);
        check("acq16_state",  state,    2);
        check("acq16_good",   good_cnt, 16);
        repeat (45) @(negedge fpga_clk);
        ref_clk = 1'b0;
        repeat (50) @(negedge fpga_clk);
        check("locked_timeout", timeout, 0);

        // Three bad samples -> SLIP holding lock, then a good one recovers.
        lost_base = lost_pulses;
        for (int i = 0; i < 3; i++) begin
            send(-5);
            check("slip_state",  state,  3);
            check("slip_locked", locked, 1);
        end
        send(0);
        check("recover_state",  state,    2);
        check("recover_locked", locked,   1);
        check("recover_good",   good_cnt, 16);
        check("recover_nolost", lost_pulses - lost_base, 0);

        // Four samples at the most negative code -> loss of lock.
        for (int i = 0; i < 3; i++) send(-128);
        check("min_slip_state", state, 3);
        send(-128);
        check("lost_state",  state,    1);
        check("lost_locked", locked,   0);
        check("lost_good",   good_cnt, 0);
        check("lost_pulse",  lost_pulses - lost_base, 1);

        // Boundary errors +/-2 count as good; 3 breaks the run.
        for (int i = 0; i < 10; i++) send((i % 2) != 0 ? -2 : 2);
        check("tol10_good",   good_cnt, 10);
        check("tol10_state",  state,    1);
        send(3);
        check("tol3_good",    good_cnt, 0);
        check("tol3_locked",  locked,   0);
        for (int i = 0; i < 15; i++) send(0);
        check("reacq15_good",   good_cnt, 15);
        check("reacq15_locked", locked,   0);
        send(0);
        check("reacq16_locked", locked, 1);
        check("reacq16_state",  state,  2);

        // Dropping enable while locked -> IDLE without a pulse.
        lost_base = lost_pulses;
        enable    = 1'b0;
        @(negedge fpga_clk);
        check("dis_state",  state,    0);
        check("dis_locked", locked,   0);
        check("dis_good",   good_cnt, 0);
        enable = 1'b1;
        repeat (2) @(negedge fpga_clk);
        check("reen_state", state, 1);
        for (int i = 0; i < 16; i++) send(-1);
        check("relock_locked", locked, 1);

        // While locked: start a sample, drop enable, then reset mid-cycle.
        error   = 8'sd0;
        ref_clk = 1'b1;
        repeat (2) @(negedge fpga_clk);
        enable = 1'b0;
        @(negedge fpga_clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state",   state,     0);
        check("arst_locked",  locked,    0);
        check("arst_good",    good_cnt,  0);
        check("arst_lost",    lock_lost, 0);
        check("arst_timeout", timeout,   0);
        repeat (5) @(negedge fpga_clk);
        check("arst_nolost", lost_pulses - lost_base, 0);
        ref_clk = 1'b0;
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (10) @(negedge fpga_clk);

`ifdef LOCK_DET_TIMEOUT_EN
        // Stop the reference while locked -> watchdog forces ACQUIRE.
        for (int i = 0; i < 16; i++) send(1);
        check("wd_prelock", locked, 1);
        lost_base = lost_pulses;
        repeat (800) @(negedge fpga_clk);
        check("wd_early_timeout", timeout, 0);
        check("wd_early_state",   state,   2);
        repeat (300) @(negedge fpga_clk);
        check("wd_timeout", timeout, 1);
        check("wd_state",   state,   1);
        check("wd_locked",  locked,  0);
        check("wd_pulse",   lost_pulses - lost_base, 1);
`else
        // Without the watchdog a silent reference leaves ACQUIRE untouched.
        repeat (1100) @(negedge fpga_clk);
        check("nowd_timeout", timeout, 0);
        check("nowd_state",   state,   1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
